// File: rtl/sdram_sample_slave_pkg.sv
// Shared constants for the SDRAM sample slave: Avalon widths, word stride
// and default return timing.
package sdram_sample_slave_pkg;

  localparam int AV_ADDR_W        = 24;
  localparam int AV_DATA_W        = 32;
  localparam int SDRAM_WORD_SKIP  = 4;
  localparam int WORD_SHIFT       = $clog2(SDRAM_WORD_SKIP);
  localparam int DEF_READ_LATENCY = 3;
  localparam int DEF_MAX_PENDING  = 3;
  // Wide enough for the largest legal pending count (8).
  localparam int PEND_W           = 4;

endpackage

// File: rtl/sdram_sample_slave_read_pipe.sv
// Read return pipe: carries RAM read results from the top's read register
// through the remaining latency stages to readdata/readdatavalid, and tracks
// how many accepted reads have not yet been returned.
module avalon_read_pipe
  import sdram_sample_slave_pkg::*;
#(
  parameter int READ_LATENCY = DEF_READ_LATENCY,
  parameter int MAX_PENDING  = DEF_MAX_PENDING,
  parameter int DATA_W       = AV_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              acceptRead,
  input  logic              inVld,
  input  logic [DATA_W-1:0] inData,
  output logic              retVld,
  output logic [DATA_W-1:0] retData,
  output logic [PEND_W-1:0] pending,
  output logic              full
);

  // The top's RAM read register is the first latency stage, so this pipe
  // adds READ_LATENCY-1 intermediate stages plus the output stage.
  localparam int MID = READ_LATENCY - 1;
  localparam logic [PEND_W-1:0] MAX_PEND = PEND_W'(MAX_PENDING);

  logic [MID-1:0]    vld_p;
  logic [DATA_W-1:0] dat_p [MID];

  // Valid shift chain and return strobe; cleared by reset so in-flight reads are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p  <= '0;
      retVld <= 1'b0;
    end else begin
      vld_p[0] <= inVld;
      for (int k = 1; k < MID; k++) begin
        vld_p[k] <= vld_p[k-1];
      end
      retVld <= vld_p[MID-1];
    end
  end

  // Intermediate data stages; only move when their stage carries a valid read.
  always_ff @(posedge clk) begin
    if (inVld) begin
      dat_p[0] <= inData;
    end
    for (int k = 1; k < MID; k++) begin
      if (vld_p[k-1]) begin
        dat_p[k] <= dat_p[k-1];
      end
    end
  end

  // Output data register holds the last returned word between returns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retData <= '0;
    end else if (vld_p[MID-1]) begin
      retData <= dat_p[MID-1];
    end
  end

  // Outstanding-read count: up on accept, down on return, unchanged when both.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      case ({acceptRead, retVld})
        2'b10:   pending <= pending + PEND_W'(1);
        2'b01:   pending <= pending - PEND_W'(1);
        default: pending <= pending;
      endcase
    end
  end

  assign full = (pending == MAX_PEND);

endmodule

// File: rtl/sdram_sample_slave.sv
// Avalon-MM pipelined slave backed by an on-chip word RAM. Fixed read
// latency, waitrequest backpressure, in-order readdatavalid returns, plus
// access counters and a sticky read+write protocol error flag.
module sdram_sample_slave
  import sdram_sample_slave_pkg::*;
#(
  parameter int DEPTH_LOG2   = 10,
  parameter int READ_LATENCY = DEF_READ_LATENCY,
  parameter int MAX_PENDING  = DEF_MAX_PENDING
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [AV_ADDR_W-1:0] address,
  input  logic                 read,
  input  logic                 write,
  input  logic [AV_DATA_W-1:0] writedata,
  output logic                 waitrequest,
  output logic [AV_DATA_W-1:0] readdata,
  output logic                 readdatavalid,
  input  logic                 stall_req,
  output logic [31:0]          rd_count,
  output logic [31:0]          wr_count,
  output logic                 protocol_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [AV_DATA_W-1:0]  mem [DEPTH];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  acceptRead;
  logic                  acceptWrite;
  logic                  pipeFull;
  logic [PEND_W-1:0]     pendingCnt;
  logic                  rdVld_p0;
  logic [AV_DATA_W-1:0]  rdData_p0;
  logic                  unusedBits;

  // Byte address to word index; upper bits alias, byte-lane bits are ignored.
  assign idx        = address[DEPTH_LOG2+WORD_SHIFT-1:WORD_SHIFT];
  assign unusedBits = ^{address[AV_ADDR_W-1:DEPTH_LOG2+WORD_SHIFT],
                        address[WORD_SHIFT-1:0], pendingCnt};

  // Backpressure: a read waits only when the return window is full and no
  // return frees a slot this cycle; a write (which wins over a read) never waits on it.
  always_comb begin
    waitrequest = reset | stall_req | (read & ~write & pipeFull & ~readdatavalid);
  end

  assign acceptWrite = write & ~waitrequest;
  assign acceptRead  = read & ~write & ~waitrequest;

  // Word RAM: write port plus registered read port (first latency stage).
  always_ff @(posedge clk) begin
    if (acceptWrite) begin
      mem[idx] <= writedata;
    end
    if (acceptRead) begin
      rdData_p0 <= mem[idx];
    end
  end

  // Read-valid for the RAM register stage, dropped on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdVld_p0 <= 1'b0;
    end else begin
      rdVld_p0 <= acceptRead;
    end
  end

  // Accepted-access counters, wrapping silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (acceptRead) begin
        rd_count <= rd_count + 32'd1;
      end
      if (acceptWrite) begin
        wr_count <= wr_count + 32'd1;
      end
    end
  end

  // Sticky flag for read and write driven together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      protocol_err <= 1'b0;
    end else if (read & write) begin
      protocol_err <= 1'b1;
    end
  end

  // ---- stage p0 -> return pipe ----
  avalon_read_pipe #(
    .READ_LATENCY (READ_LATENCY),
    .MAX_PENDING  (MAX_PENDING),
    .DATA_W       (AV_DATA_W)
  ) uReadPipe (
    .clk        (clk),
    .reset      (reset),
    .acceptRead (acceptRead),
    .inVld      (rdVld_p0),
    .inData     (rdData_p0),
    .retVld     (readdatavalid),
    .retData    (readdata),
    .pending    (pendingCnt),
    .full       (pipeFull)
  );

endmodule

// File: tb/tb_sdram_sample_slave.sv
// Bench for sdram_sample_slave: directed scenarios followed by randomized
// traffic, checked against a queue-based transaction model.
module tb_sdram_sample_slave;

  localparam int L    = 3;
  localparam int MAXP = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        stall_req;
  logic [31:0] rd_count;
  logic [31:0] wr_count;
  logic        protocol_err;

  sdram_sample_slave #(
    .DEPTH_LOG2   (10),
    .READ_LATENCY (L),
    .MAX_PENDING  (MAXP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .waitrequest   (waitrequest),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .stall_req     (stall_req),
    .rd_count      (rd_count),
    .wr_count      (wr_count),
    .protocol_err  (protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          due;
  } ret_t;

  ret_t        q[$];
  logic [31:0] mdl [1024];
  int          cyc;
  logic [31:0] mRd, mWr, lastData;
  logic        mErr;
  int          nTotal, nPass;

  function automatic int widx(input logic [23:0] a);
    return (int'(a) / 4) % 1024;
  endfunction

  function automatic logic [23:0] randAddr();
    logic [23:0] a;
    a = 24'($urandom);
    a[11:2] = 10'($urandom_range(0, 15));
    return a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTotal++;
    assert (obs === exp) nPass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic modelReset();
    q.delete();
    mRd = 0;
    mWr = 0;
    mErr = 1'b0;
    lastData = 0;
  endtask

  // One clock cycle: check waitrequest before the edge, advance the model, check outputs after.
  task automatic tick(output bit accR, output bit accW);
    bit   expRdv;
    bit   expWait;
    ret_t r;
    #1;
    expRdv  = (q.size() > 0) && (q[0].due == cyc);
    expWait = stall_req || (read && !write && q.size() == MAXP && !expRdv);
    chk("waitrequest", waitrequest, expWait);
    accW = write && !expWait;
    accR = read && !write && !expWait;
    if (read && write) mErr = 1'b1;
    @(posedge clk);
    cyc++;
    if (expRdv) void'(q.pop_front());
    if (accR) begin
      r.data = mdl[widx(address)];
      r.due  = cyc + L;
      q.push_back(r);
      mRd++;
    end
    if (accW) begin
      mdl[widx(address)] = writedata;
      mWr++;
    end
    #1;
    expRdv = (q.size() > 0) && (q[0].due == cyc);
    chk("readdatavalid", readdatavalid, expRdv);
    if (expRdv) lastData = q[0].data;
    chk("readdata", readdata, lastData);
    chk("rd_count", rd_count, mRd);
    chk("wr_count", wr_count, mWr);
    chk("protocol_err", protocol_err, mErr);
  endtask

  task automatic idle(input int n);
    bit a, b;
    read = 1'b0;
    write = 1'b0;
    for (int i = 0; i < n; i++) tick(a, b);
  endtask

  task automatic doWrite(input logic [23:0] a, input logic [31:0] d);
    bit ar, aw;
    read = 1'b0;
    write = 1'b1;
    address = a;
    writedata = d;
    aw = 1'b0;
    for (int i = 0; i < 20 && !aw; i++) tick(ar, aw);
    if (!aw) chk("write_accept_timeout", 0, 1);
    write = 1'b0;
  endtask

  // Holds read until accepted; returns how many cycles it waited.
  task automatic doRead(input logic [23:0] a, output int waited);
    bit ar, aw;
    write = 1'b0;
    read = 1'b1;
    address = a;
    ar = 1'b0;
    waited = 0;
    for (int i = 0; i < 20 && !ar; i++) begin
      tick(ar, aw);
      if (!ar) waited++;
    end
    if (!ar) chk("read_accept_timeout", 0, 1);
  endtask

  initial begin
    bit ar, aw;
    int w, wCyc, rvCyc, accs;
    nTotal = 0;
    nPass = 0;
    cyc = 0;
    read = 1'b0;
    write = 1'b0;
    stall_req = 1'b0;
    address = '0;
    writedata = '0;
    modelReset();

    // Power-on reset values
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_readdatavalid", readdatavalid, 0);
    chk("reset_readdata", readdata, 0);
    chk("reset_rd_count", rd_count, 0);
    chk("reset_wr_count", wr_count, 0);
    chk("reset_protocol_err", protocol_err, 0);
    chk("reset_waitrequest", waitrequest, 1);
    reset = 1'b0;

    // Write then read same word: return 4 cycles after the write accept
    doWrite(24'h000010, 32'h12345678);
    wCyc = cyc;
    doRead(24'h000010, w);
    read = 1'b0;
    rvCyc = -1;
    for (int i = 0; i < 10 && rvCyc < 0; i++) begin
      if (readdatavalid === 1'b1) rvCyc = cyc;
      else tick(ar, aw);
    end
    chk("first_return_delay", rvCyc - wCyc, 4);
    chk("first_return_data", readdata, 32'h12345678);
    idle(3);
    chk("first_wr_count", wr_count, 1);
    chk("first_rd_count", rd_count, 1);

    // Back-to-back reads with the return window full on the fourth
    for (int i = 0; i < 4; i++) doWrite(24'(4 * i), 32'(i + 1));
    for (int i = 0; i < 4; i++) begin
      doRead(24'(4 * i), w);
      if (i < 3) chk("burst_no_wait", w, 0);
      else chk("burst_fourth_waited", (w > 0), 1);
    end
    read = 1'b0;
    idle(6);
    chk("burst_rd_count", rd_count, 5);

    // Address aliasing past the RAM depth
    doWrite(24'h001000, 32'hAAAA5555);
    doRead(24'h000000, w);
    read = 1'b0;
    idle(5);
    chk("alias_data", readdata, 32'hAAAA5555);

    // Read and write together: write wins, read ignored, error sticks
    read = 1'b1;
    write = 1'b1;
    address = 24'h000008;
    writedata = 32'd7;
    tick(ar, aw);
    chk("rw_write_accepted", aw, 1);
    idle(5);
    doRead(24'h000008, w);
    read = 1'b0;
    idle(5);
    chk("rw_readback", readdata, 32'd7);
    chk("rw_err_sticky", protocol_err, 1);

    // Stall with two reads in flight
    doRead(24'h000004, w);
    doRead(24'h00000C, w);
    stall_req = 1'b1;
    address = 24'h000000;
    accs = 0;
    for (int i = 0; i < 5; i++) begin
      tick(ar, aw);
      if (ar) accs++;
    end
    chk("stall_no_accepts", accs, 0);
    stall_req = 1'b0;
    idle(4);

    // Reset one cycle after a read accept drops the read
    doRead(24'h000010, w);
    read = 1'b0;
    #2;
    reset = 1'b1;
    modelReset();
    #1;
    chk("midreset_readdatavalid", readdatavalid, 0);
    chk("midreset_rd_count", rd_count, 0);
    chk("midreset_protocol_err", protocol_err, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(6);
    for (int i = 0; i < 3; i++) begin
      doRead(24'(4 * i), w);
      chk("post_reset_no_wait", w, 0);
    end
    read = 1'b0;
    idle(6);

    // Randomized traffic over an aliased 16-word window
    for (int i = 0; i < 16; i++) doWrite(randAddr() & 24'hFFFFF3 | 24'(i << 2), $urandom);
    for (int i = 0; i < 300; i++) begin
      read = 1'($urandom_range(0, 1));
      write = ($urandom_range(0, 3) == 0);
      stall_req = ($urandom_range(0, 5) == 0);
      address = randAddr();
      writedata = $urandom;
      tick(ar, aw);
    end
    stall_req = 1'b0;
    idle(8);

    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule

// File: doc/sdram_sample_slave.md
Name: sdram_sample_slave

Overview:
- Avalon-MM pipelined slave that responds to the filter engines' SDRAM master port.
- Internal word RAM with fixed read latency, waitrequest backpressure, and readdatavalid returns.
- Used as an on-chip sample store and as a bus-accurate SDRAM stand-in for block-level benches.
- Accepts byte addresses at 4-byte word stride, matching the SDRAM word skip used by the master side.

Parameters:
- DEPTH_LOG2, 10, log2 of RAM depth in 32-bit words (1024 words).
- READ_LATENCY, 3, cycles from read acceptance to readdatavalid; legal range 2..8.
- MAX_PENDING, 3, maximum accepted-but-unreturned reads; legal range 1..READ_LATENCY.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  24  byte address; bits [DEPTH_LOG2+1:2] index the RAM; other bits ignored.
- read  in  1  read request.
- write  in  1  write request.
- writedata  in  32  write data.
- waitrequest  out  1  request not accepted this cycle.
- readdata  out  32  read return data.
- readdatavalid  out  1  readdata valid this cycle.
- stall_req  in  1  bench/host-forced backpressure.
- rd_count  out  32  accepted reads.
- wr_count  out  32  accepted writes.
- protocol_err  out  1  sticky: read and write asserted together.

Behaviour:
- Reset values: readdatavalid 0, readdata 0, rd_count 0, wr_count 0, protocol_err 0, pending 0. RAM contents are not reset.
- Reset clears the return pipeline; in-flight reads are dropped and raise no readdatavalid after reset.
- waitrequest (combinational) = reset | stall_req | (read & pending == MAX_PENDING & no return this cycle).
  - Writes never wait except on reset or stall_req.
- A request is accepted on a clk edge when it is asserted and waitrequest is low.
- Write accept:
  - RAM[idx] <= writedata on the same edge; wr_count++.
  - A read accepted on any later cycle returns the new data.
- Read accept at edge t:
  - RAM is read with the index captured at t.
  - Result travels a delay line; readdatavalid is high for exactly one cycle at edge t+READ_LATENCY, with readdata set.
  - Returns are strictly in acceptance order.
  - Back-to-back accepts give back-to-back returns.
  - rd_count++.
- readdata holds its last value when readdatavalid is low.
- pending:
  - +1 on read accept, −1 on return; both in the same cycle leave it unchanged.
  - Never exceeds MAX_PENDING and never underflows.
- read and write together:
  - Write has priority and is accepted; the read is ignored and not counted.
  - protocol_err is set and stays set until reset.
- Address wrap: index = address[DEPTH_LOG2+1:2]. Addresses past the depth alias modulo the depth; no error is flagged.
- Counters wrap at 2^32 silently.
- stall_req asserted mid-stream:
  - New accepts stop immediately.
  - Already-accepted reads still return on schedule.

Decomposition:
- Shared package holds:
  - Avalon width constants: address 24, data 32.
  - SDRAM_WORD_SKIP = 4.
  - Default READ_LATENCY and MAX_PENDING.
- One natural sub-module: avalon_read_pipe. It is a READ_LATENCY-deep valid/data shift pipe with a pending counter and returns pending and the return strobe.
- The top level holds the RAM, accept logic, counters and error flag.

Test Plan:
- Write 0x12345678 to address 0x000010, then read 0x000010 -> 4 cycles after write accept, readdatavalid pulses once with 0x12345678 (READ_LATENCY 3 after read accept); wr_count=1, rd_count=1.
- Read addresses 0x0,0x4,0x8,0xC, asserted continuously, preloaded 1,2,3,4 -> first three accepted back-to-back; 4th sees waitrequest until the first return, then is accepted. Returns are 1,2,3,4 in order; rd_count=4.
- Write 0xAAAA5555 to 0x001000 (aliases index 0) and read 0x000000 -> 0xAAAA5555 returned.
- Drive read=write=1 at 0x8 with writedata 7 -> write accepted, no readdatavalid, rd_count unchanged, protocol_err=1 until reset.
- Assert stall_req while two reads are in flight -> both return on schedule, waitrequest=1 throughout, no new accepts.
- Accept a read, then assert reset one cycle later -> no readdatavalid ever appears. After reset, counters=0, pending=0 and the slave accepts normally.
